// File: rtl/bcd_digit_scanner_pkg.sv
// Shared definitions for the BCD digit scanner.
//   slot_state_e : phase of a digit slot (blank gap, then digit shown)
//   BCD_MAX      : largest displayable BCD code; anything above is blanked
//   ANODE_OFF    : all-anodes-off pattern, sliced to the digit count in use
//   clog2        : ceiling log2 for counter and index widths (minimum 1)
package bcd_digit_scanner_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } slot_state_e;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 8;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bcd_digit_scanner_if.sv
// Bus between the digit scanner and its environment.
//   digits_in  : packed BCD digits, [3:0] = digit 0
//   load       : 1-cycle strobe capturing digits_in into the pending register
//   ai..di     : BCD code to the 7-segment converter, ai = MSB
//   an         : active-low anode enables, an[0] = digit 0
//   frame_done : 1-cycle pulse on the last shown cycle of a full scan
// master = the side that supplies digits; slave = the scanner.
interface bcd_digit_scanner_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] digits_in;
  logic                  load;
  logic                  ai;
  logic                  bi;
  logic                  ci;
  logic                  di;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_done;

  modport master (
    output digits_in, load,
    input  ai, bi, ci, di, an, frame_done
  );

  modport slave (
    input  digits_in, load,
    output ai, bi, ci, di, an, frame_done
  );
endinterface

// File: rtl/bcd_digit_scanner_slot_timer.sv
// Per-slot timer: counts SLOT_CYCLES clocks per digit slot, the first
// BLANK_CYCLES of which are the blanking gap.
//   clk, rst    : clock, async active-high reset
//   show_o      : slot is currently in the SHOW phase
//   to_show_o   : last BLANK cycle (next cycle enters SHOW)
//   pre_end_o   : second-to-last cycle of the slot
//   slot_end_o  : last cycle of the slot (next cycle starts a new slot)
// The look-ahead flags let the top level register its outputs so they line
// up with the phase they belong to.
//
// state   | meaning
// S_BLANK | anodes off, BCD code settling for the slot's digit
// S_SHOW  | slot digit driven onto its anode (unless blanked)
module bcd_digit_scanner_slot_timer
  import bcd_digit_scanner_pkg::*;
#(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic show_o,
  output logic to_show_o,
  output logic pre_end_o,
  output logic slot_end_o
);

  localparam int CNT_W = clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_PRE   = CNT_W'(SLOT_CYCLES - 2);

  slot_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BLANK;
      cnt_q   <= '0;
    end else begin
      if (cnt_q == SLOT_LAST) begin
        cnt_q   <= '0;
        state_q <= S_BLANK;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        if (state_q == S_BLANK && cnt_q == BLANK_LAST) begin
          state_q <= S_SHOW;
        end
      end
    end
  end

  assign show_o     = (state_q == S_SHOW);
  assign to_show_o  = (state_q == S_BLANK) && (cnt_q == BLANK_LAST);
  assign pre_end_o  = (cnt_q == SLOT_PRE);
  assign slot_end_o = (cnt_q == SLOT_LAST);

endmodule

// File: rtl/bcd_digit_scanner.sv
// Time-multiplexes N_DIGITS packed BCD digits onto one 4-bit converter input
// and drives the active-low digit anodes, with a blanking gap at the start of
// every slot, leading-zero suppression and blanking of non-BCD codes.
// New digits are staged in a pending register and only reach the display
// register at the frame boundary, so a frame never shows a mix of old/new.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of bcd_digit_scanner_if (digits_in, load in;
//              ai..di, an, frame_done out, all registered)
module bcd_digit_scanner
  import bcd_digit_scanner_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit LZ_SUPPRESS  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_digit_scanner_if.slave   bus
);

  localparam int IDX_W = clog2(N_DIGITS);
  localparam int DW    = 4 * N_DIGITS;
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF   = ANODE_OFF[N_DIGITS-1:0];

  logic slot_show;
  logic slot_to_show;
  logic slot_pre_end;
  logic slot_end;

  bcd_digit_scanner_slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .show_o     (slot_show),
    .to_show_o  (slot_to_show),
    .pre_end_o  (slot_pre_end),
    .slot_end_o (slot_end)
  );

  logic [IDX_W-1:0]    idx_q,        idx_d;
  logic [DW-1:0]       disp_q,       disp_d;
  logic [DW-1:0]       pend_q,       pend_d;
  logic                pend_flag_q,  pend_flag_d;
  logic [N_DIGITS-1:0] an_q,         an_d;
  logic [3:0]          bcd_q,        bcd_d;
  logic                frame_done_q, frame_done_d;

  logic       wrap;
  logic       show_d;
  logic [3:0] digit_d;
  logic       higher_zero;
  logic       blank_d;

  // Outputs are computed from the next-cycle slot state so that, once
  // registered, they coincide with the phase they describe.
  always_comb begin
    wrap = slot_end && (idx_q == IDX_LAST);

    idx_d = idx_q;
    if (slot_end) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    pend_d      = bus.load ? bus.digits_in : pend_q;
    pend_flag_d = pend_flag_q | bus.load;
    disp_d      = disp_q;
    if (wrap) begin
      pend_flag_d = 1'b0;
      // A load on the wrap cycle itself wins over the older pending value.
      if (bus.load) begin
        disp_d = bus.digits_in;
      end else if (pend_flag_q) begin
        disp_d = pend_q;
      end
    end

    show_d  = !slot_end && (slot_to_show || slot_show);
    digit_d = disp_d[{idx_d, 2'b00} +: 4];

    higher_zero = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (IDX_W'(i) > idx_d && disp_d[4*i +: 4] != 4'd0) begin
        higher_zero = 1'b0;
      end
    end

    blank_d = (digit_d > BCD_MAX) ||
              (LZ_SUPPRESS && digit_d == 4'd0 && higher_zero && idx_d != '0);

    an_d = AN_OFF;
    if (show_d && !blank_d) begin
      an_d[idx_d] = 1'b0;
    end

    bcd_d        = digit_d;
    frame_done_d = slot_pre_end && (idx_q == IDX_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_flag_q  <= 1'b0;
      an_q         <= AN_OFF;
      bcd_q        <= 4'd0;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_flag_q  <= pend_flag_d;
      an_q         <= an_d;
      bcd_q        <= bcd_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.ai         = bcd_q[3];
  assign bus.bi         = bcd_q[2];
  assign bus.ci         = bcd_q[1];
  assign bus.di         = bcd_q[0];
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Bench for bcd_digit_scanner: two instances (leading-zero suppression on and
// off) share stimulus; every cycle is compared against a frame-position model.
module tb_bcd_digit_scanner;

  localparam int N    = 4;
  localparam int SLOT = 8;
  localparam int BLNK = 2;
  localparam int FRAME = N * SLOT;

  logic clk;
  logic rst;

  bcd_digit_scanner_if #(.N_DIGITS(N)) bus1 ();
  bcd_digit_scanner_if #(.N_DIGITS(N)) bus2 ();

  assign bus2.digits_in = bus1.digits_in;
  assign bus2.load      = bus1.load;

  bcd_digit_scanner #(
    .N_DIGITS(N), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLNK), .LZ_SUPPRESS(1'b1)
  ) dut_lz (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  bcd_digit_scanner #(
    .N_DIGITS(N), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLNK), .LZ_SUPPRESS(1'b0)
  ) dut_nolz (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // model state: position within frame, displayed and pending values
  int          pos;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_flag;

  function automatic logic [3:0] exp_an(input logic [15:0] d, input int p, input bit lz);
    int         idx;
    logic [3:0] code;
    bit         blank;
    idx   = p / SLOT;
    code  = d[4*idx +: 4];
    blank = (code > 4'd9);
    if (lz && idx != 0 && code == 4'd0 && (d >> (4 * (idx + 1))) == 16'd0) blank = 1'b1;
    if ((p % SLOT) >= BLNK && !blank) return ~(4'b0001 << idx);
    return 4'b1111;
  endfunction

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v[4*i +: 4] = ($urandom_range(2, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 0));
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (frame pos %0d, time %0t)", tag, obs, expv, pos, $time);
    end
  endtask

  task automatic check();
    logic [3:0] ebcd;
    ebcd = m_disp[4*(pos/SLOT) +: 4];
    chk("an_lz",    {4'b0, bus1.an}, {4'b0, exp_an(m_disp, pos, 1'b1)});
    chk("bcd_lz",   {4'b0, bus1.ai, bus1.bi, bus1.ci, bus1.di}, {4'b0, ebcd});
    chk("fdone_lz", {7'b0, bus1.frame_done}, {7'b0, (pos == FRAME - 1)});
    chk("an_nolz",  {4'b0, bus2.an}, {4'b0, exp_an(m_disp, pos, 1'b0)});
    chk("bcd_nolz", {4'b0, bus2.ai, bus2.bi, bus2.ci, bus2.di}, {4'b0, ebcd});
    chk("fdone_nolz", {7'b0, bus2.frame_done}, {7'b0, (pos == FRAME - 1)});
  endtask

  task automatic check_reset();
    chk("rst_an_lz",   {4'b0, bus1.an}, 8'h0f);
    chk("rst_bcd_lz",  {4'b0, bus1.ai, bus1.bi, bus1.ci, bus1.di}, 8'h00);
    chk("rst_fd_lz",   {7'b0, bus1.frame_done}, 8'h00);
    chk("rst_an_nolz", {4'b0, bus2.an}, 8'h0f);
  endtask

  task automatic model_reset();
    pos    = 0;
    m_disp = 16'h0;
    m_pend = 16'h0;
    m_flag = 1'b0;
  endtask

  // one clock: optional load strobe, model update at the edge, check after it
  task automatic tick(input bit ld, input logic [15:0] val);
    @(negedge clk);
    bus1.load      = ld;
    bus1.digits_in = ld ? val : 16'($urandom);
    @(posedge clk);
    if (pos == FRAME - 1) begin
      if (ld) m_disp = val;
      else if (m_flag) m_disp = m_pend;
      m_flag = 1'b0;
      if (ld) m_pend = val;
    end else if (ld) begin
      m_pend = val;
      m_flag = 1'b1;
    end
    pos = (pos + 1) % FRAME;
    #1;
    bus1.load = 1'b0;
    check();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b0, 16'h0);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < FRAME && pos != target; i++) tick(1'b0, 16'h0);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 check_reset();
    model_reset();
    @(posedge clk);
    #1 check_reset();
    #1 rst = 1'b0;
    check();
  endtask

  initial begin
    rst            = 1'b1;
    bus1.load      = 1'b0;
    bus1.digits_in = 16'h0;
    model_reset();
    #12 check_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    check();

    // 1: first load is held until the wrap, then digits scan 0..3
    tick(1'b1, 16'h1234);
    run(2 * FRAME);

    // 2: leading zeros, with and without suppression
    tick(1'b1, 16'h0070);
    run(2 * FRAME);

    // 3: non-BCD code blanked
    tick(1'b1, 16'h12A4);
    run(2 * FRAME);

    // 4: two loads mid-frame, last one wins at the wrap
    run_to(9);
    tick(1'b1, 16'h5555);
    tick(1'b0, 16'h0);
    tick(1'b1, 16'h6666);
    run(2 * FRAME);
    // load landing exactly on the wrap cycle
    run_to(FRAME - 1);
    tick(1'b1, 16'h9081);
    run(FRAME + 3);

    // 5: reset during SHOW of digit 2 discards a pending load
    run_to(5);
    tick(1'b1, 16'h4321);
    run_to(2 * SLOT + 4);
    pulse_reset();
    run(2 * FRAME);

    // random loads, including invalid codes and leading zeros
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(7, 0) == 0), rand_digits());
    end
    run_to(3 * SLOT + 5);
    pulse_reset();
    for (int i = 0; i < 200; i++) begin
      tick(($urandom_range(5, 0) == 0), rand_digits());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
